// File: rtl/mor1kx_tlb_reload_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_tlb_reload_arbiter
// Purpose  : Shares one memory read port between the IMMU and DMMU hardware
//            TLB-reload walkers. A walker keeps the port for its whole
//            page-table walk (pointer fetch plus PTE fetch) while its request
//            stays high. Contention is resolved round-robin, and a stalled
//            access is aborted after OPTION_RELOAD_TIMEOUT cycles.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            immu_req_i/immu_addr_i   - IMMU walk request and access address
//            immu_ack_o/data_o/err_o  - IMMU per-access completion, data, error
//            dmmu_*                   - same set for the DMMU walker
//            mem_req_o/mem_addr_o     - shared read port request and address
//            mem_ack_i/err_i/data_i   - shared read port completion and data
//            grant_o                  - {dmmu, immu} one-hot current owner
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_tlb_reload_arbiter #(
  parameter int OPTION_OPERAND_WIDTH  = 32,
  parameter int OPTION_RELOAD_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic                            immu_err_o,

  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  output logic                            dmmu_err_o,

  output logic                            mem_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mem_addr_o,
  input  logic                            mem_ack_i,
  input  logic                            mem_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mem_data_i,

  output logic [1:0]                      grant_o
);

  localparam logic [15:0] c_timeout    = 16'(OPTION_RELOAD_TIMEOUT);
  localparam logic        c_timeout_en = (OPTION_RELOAD_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_grant_d;  // 1: DMMU was granted most recently
  logic [15:0] r_timeout_cnt;

  logic                            w_owner_i;
  logic                            w_owner_d;
  logic                            w_owner_req;
  logic [OPTION_OPERAND_WIDTH-1:0] w_owner_addr;
  logic                            w_timeout_hit;
  logic                            w_mem_req;
  logic                            w_ack;
  logic                            w_err;
  logic [OPTION_OPERAND_WIDTH-1:0] w_data;

  // --------------------------------------------------------------------------
  // Ownership decode
  // --------------------------------------------------------------------------
  assign w_owner_i    = (r_state == ST_GRANT_I);
  assign w_owner_d    = (r_state == ST_GRANT_D);
  assign w_owner_req  = (w_owner_i & immu_req_i) | (w_owner_d & dmmu_req_i);
  assign w_owner_addr = w_owner_i ? immu_addr_i :
                        w_owner_d ? dmmu_addr_i : '0;

  // --------------------------------------------------------------------------
  // Timeout: an ack or error in the match cycle takes precedence, so the
  // abort only fires when the bus has given no response at all.
  // --------------------------------------------------------------------------
  assign w_timeout_hit = c_timeout_en & ~rst & w_owner_req & ~mem_ack_i &
                         ~mem_err_i & (r_timeout_cnt == c_timeout);

  // Dropping mem_req_o in the abort cycle is how the bus sees a cancel.
  assign w_mem_req = ~rst & w_owner_req & ~w_timeout_hit;

  // Response shaping: errors and timeouts return zero data so the walker
  // takes its pagefault path (null pointer / PRESENT=0).
  assign w_ack  = (w_mem_req & (mem_ack_i | mem_err_i)) | w_timeout_hit;
  assign w_err  = (w_mem_req & mem_err_i) | w_timeout_hit;
  assign w_data = (w_mem_req & mem_ack_i & ~mem_err_i) ? mem_data_i : '0;

  // --------------------------------------------------------------------------
  // Output routing: only the owner sees responses; everything is held at
  // zero while reset is asserted.
  // --------------------------------------------------------------------------
  assign mem_req_o   = w_mem_req;
  assign mem_addr_o  = rst ? '0 : w_owner_addr;
  assign grant_o     = rst ? 2'b00 : {w_owner_d, w_owner_i};

  assign immu_ack_o  = w_owner_i & w_ack;
  assign immu_err_o  = w_owner_i & w_err;
  assign immu_data_o = w_owner_i ? w_data : '0;

  assign dmmu_ack_o  = w_owner_d & w_ack;
  assign dmmu_err_o  = w_owner_d & w_err;
  assign dmmu_data_o = w_owner_d ? w_data : '0;

  // --------------------------------------------------------------------------
  // Next-state logic. On release the other walker is granted directly if it
  // is waiting, which gives a zero-bubble handover.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (immu_req_i && dmmu_req_i) begin
          w_state_next = r_last_grant_d ? ST_GRANT_I : ST_GRANT_D;
        end else if (immu_req_i) begin
          w_state_next = ST_GRANT_I;
        end else if (dmmu_req_i) begin
          w_state_next = ST_GRANT_D;
        end
      end
      ST_GRANT_I: begin
        if (!immu_req_i) begin
          w_state_next = dmmu_req_i ? ST_GRANT_D : ST_IDLE;
        end
      end
      ST_GRANT_D: begin
        if (!dmmu_req_i) begin
          w_state_next = immu_req_i ? ST_GRANT_I : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, round-robin memory and timeout counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_last_grant_d <= 1'b1;  // IMMU wins the first tie after reset
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        if (w_state_next == ST_GRANT_I) begin
          r_last_grant_d <= 1'b0;
        end else if (w_state_next == ST_GRANT_D) begin
          r_last_grant_d <= 1'b1;
        end
      end
    end
  end

  // The first mem_req_o cycle of an access counts as zero, so the abort lands
  // exactly OPTION_RELOAD_TIMEOUT cycles after the access started.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_cnt <= 16'd0;
    end else if (w_state_next != r_state) begin
      r_timeout_cnt <= 16'd0;
    end else if (w_ack) begin
      r_timeout_cnt <= 16'd0;
    end else if (w_mem_req) begin
      r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mor1kx_tlb_reload_arbiter
// Purpose  : Directed self-checking bench for mor1kx_tlb_reload_arbiter,
//            built with a reload timeout of 4 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mor1kx_tlb_reload_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         immu_req_i;
  logic [W-1:0] immu_addr_i;
  logic         immu_ack_o;
  logic [W-1:0] immu_data_o;
  logic         immu_err_o;
  logic         dmmu_req_i;
  logic [W-1:0] dmmu_addr_i;
  logic         dmmu_ack_o;
  logic [W-1:0] dmmu_data_o;
  logic         dmmu_err_o;
  logic         mem_req_o;
  logic [W-1:0] mem_addr_o;
  logic         mem_ack_i;
  logic         mem_err_i;
  logic [W-1:0] mem_data_i;
  logic [1:0]   grant_o;

  logic [102:0] all_out;
  assign all_out = {mem_req_o, mem_addr_o, grant_o, immu_ack_o, immu_err_o,
                    immu_data_o, dmmu_ack_o, dmmu_err_o, dmmu_data_o};

  int vectors;
  int miscompares;
  int dmmu_ack_seen;

  mor1kx_tlb_reload_arbiter #(
    .OPTION_OPERAND_WIDTH (W),
    .OPTION_RELOAD_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .immu_req_i (immu_req_i),
    .immu_addr_i(immu_addr_i),
    .immu_ack_o (immu_ack_o),
    .immu_data_o(immu_data_o),
    .immu_err_o (immu_err_o),
    .dmmu_req_i (dmmu_req_i),
    .dmmu_addr_i(dmmu_addr_i),
    .dmmu_ack_o (dmmu_ack_o),
    .dmmu_data_o(dmmu_data_o),
    .dmmu_err_o (dmmu_err_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_err_i  (mem_err_i),
    .mem_data_i (mem_data_i),
    .grant_o    (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dmmu_ack_o === 1'b1) dmmu_ack_seen++;
  end

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    immu_req_i = 1'b0; immu_addr_i = '0;
    dmmu_req_i = 1'b0; dmmu_addr_i = '0;
    mem_ack_i  = 1'b0; mem_err_i   = 1'b0; mem_data_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    immu_req_i = 1'b1; dmmu_req_i = 1'b1;
    immu_addr_i = 32'h0000_1111; dmmu_addr_i = 32'h0000_2222;
    mem_ack_i = 1'b1; mem_err_i = 1'b1; mem_data_i = 32'hFFFF_FFFF;
    tick(); tick(); #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    tick(); #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL post_reset_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_immu_only();
    int seen_before;
    seen_before = dmmu_ack_seen;
    immu_req_i = 1'b1; immu_addr_i = 32'h0000_1000; #1;
    vectors++;
    if (grant_o !== 2'b00 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL immu_req_cycle: grant=%b mem_req=%b expected 00/0", grant_o, mem_req_o);
    end
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b01 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_1000) begin
      miscompares++;
      $display("FAIL immu_grant: grant=%b req=%b addr=%h expected 01/1/00001000", grant_o, mem_req_o, mem_addr_o);
    end
    tick(); #1;
    vectors++;
    if (immu_ack_o !== 1'b0 || mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL immu_wait1: ack=%b req=%b expected 0/1", immu_ack_o, mem_req_o);
    end
    tick(); mem_ack_i = 1'b1; mem_data_i = 32'hABCD_2000; #1;
    vectors++;
    if (immu_ack_o !== 1'b1 || immu_err_o !== 1'b0 || immu_data_o !== 32'hABCD_2000 || dmmu_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL immu_ptr_ack: ack=%b err=%b data=%h dack=%b expected 1/0/abcd2000/0", immu_ack_o, immu_err_o, immu_data_o, dmmu_ack_o);
    end
    tick(); mem_ack_i = 1'b0; mem_data_i = '0; immu_addr_i = 32'h0000_2004; #1;
    vectors++;
    if (mem_addr_o !== 32'h0000_2004 || mem_req_o !== 1'b1 || immu_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL immu_pte_addr: addr=%h req=%b ack=%b expected 00002004/1/0", mem_addr_o, mem_req_o, immu_ack_o);
    end
    tick();
    tick(); mem_ack_i = 1'b1; mem_data_i = 32'h0000_0541; #1;
    vectors++;
    if (immu_ack_o !== 1'b1 || immu_err_o !== 1'b0 || immu_data_o !== 32'h0000_0541) begin
      miscompares++;
      $display("FAIL immu_pte_ack: ack=%b err=%b data=%h expected 1/0/00000541", immu_ack_o, immu_err_o, immu_data_o);
    end
    tick(); mem_ack_i = 1'b0; mem_data_i = '0; immu_req_i = 1'b0; #1;
    vectors++;
    if (mem_req_o !== 1'b0 || immu_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL immu_release: req=%b ack=%b expected 0/0", mem_req_o, immu_ack_o);
    end
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b00 || dmmu_ack_seen != seen_before) begin
      miscompares++;
      $display("FAIL immu_idle: grant=%b dmmu_acks=%0d expected 00/0", grant_o, dmmu_ack_seen - seen_before);
    end
  endtask

  task automatic test_tie_and_handover();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    immu_req_i = 1'b1; immu_addr_i = 32'h0000_3000;
    dmmu_req_i = 1'b1; dmmu_addr_i = 32'h0000_4000;
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b01 || mem_addr_o !== 32'h0000_3000) begin
      miscompares++;
      $display("FAIL tie1_grant: grant=%b addr=%h expected 01/00003000", grant_o, mem_addr_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h1111_1111; #1;
    vectors++;
    if (immu_ack_o !== 1'b1 || dmmu_ack_o !== 1'b0 || immu_data_o !== 32'h1111_1111 || dmmu_data_o !== '0) begin
      miscompares++;
      $display("FAIL tie1_ack_route: iack=%b dack=%b idata=%h ddata=%h expected 1/0/11111111/0", immu_ack_o, dmmu_ack_o, immu_data_o, dmmu_data_o);
    end
    tick(); mem_ack_i = 1'b0; mem_data_i = '0; immu_req_i = 1'b0; #1;
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL tie1_drop: mem_req=%b expected 0", mem_req_o);
    end
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b10 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_4000) begin
      miscompares++;
      $display("FAIL handover: grant=%b req=%b addr=%h expected 10/1/00004000", grant_o, mem_req_o, mem_addr_o);
    end
    // Owner abandons its walk without an ack: the request falls at once.
    dmmu_req_i = 1'b0; #1;
    vectors++;
    if (mem_req_o !== 1'b0 || dmmu_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL dmmu_cancel: req=%b ack=%b expected 0/0", mem_req_o, dmmu_ack_o);
    end
    tick(); immu_req_i = 1'b1; dmmu_req_i = 1'b1; #1;
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL tie2_idle: grant=%b expected 00", grant_o);
    end
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL tie2_grant: grant=%b expected 01", grant_o);
    end
    immu_req_i = 1'b0; dmmu_req_i = 1'b0;
    tick(); immu_req_i = 1'b1; dmmu_req_i = 1'b1; #1;
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL tie3_idle: grant=%b expected 00", grant_o);
    end
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b10 || mem_addr_o !== 32'h0000_4000) begin
      miscompares++;
      $display("FAIL tie3_grant: grant=%b addr=%h expected 10/00004000", grant_o, mem_addr_o);
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_err_wins();
    dmmu_req_i = 1'b1; dmmu_addr_i = 32'h0000_5000;
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b10 || mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_grant: grant=%b req=%b expected 10/1", grant_o, mem_req_o);
    end
    mem_ack_i = 1'b1; mem_err_i = 1'b1; mem_data_i = 32'hFFFF_FFFF; #1;
    vectors++;
    if (dmmu_ack_o !== 1'b1 || dmmu_err_o !== 1'b1 || dmmu_data_o !== '0 || immu_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_wins: ack=%b err=%b data=%h iack=%b expected 1/1/0/0", dmmu_ack_o, dmmu_err_o, dmmu_data_o, immu_ack_o);
    end
    tick(); clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    immu_req_i = 1'b1; immu_addr_i = 32'h0000_6000; mem_data_i = 32'hDEAD_BEEF;
    tick();
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 4; i++) begin
        #1;
        vectors++;
        if (mem_req_o !== 1'b1 || immu_ack_o !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_wait r%0d c%0d: req=%b ack=%b expected 1/0", round, i, mem_req_o, immu_ack_o);
        end
        tick();
      end
      #1;
      vectors++;
      if (mem_req_o !== 1'b0 || immu_ack_o !== 1'b1 || immu_err_o !== 1'b1 || immu_data_o !== '0) begin
        miscompares++;
        $display("FAIL timeout_hit r%0d: req=%b ack=%b err=%b data=%h expected 0/1/1/0", round, mem_req_o, immu_ack_o, immu_err_o, immu_data_o);
      end
      tick();
    end
    // Ack arriving on the match cycle beats the timeout.
    for (int i = 0; i < 4; i++) tick();
    mem_ack_i = 1'b1; #1;
    vectors++;
    if (mem_req_o !== 1'b1 || immu_ack_o !== 1'b1 || immu_err_o !== 1'b0 || immu_data_o !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL timeout_ack_race: req=%b ack=%b err=%b data=%h expected 1/1/0/deadbeef", mem_req_o, immu_ack_o, immu_err_o, immu_data_o);
    end
    tick(); clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_walk();
    immu_req_i = 1'b1; immu_addr_i = 32'h0000_7000;
    dmmu_req_i = 1'b1; dmmu_addr_i = 32'h0000_8000;
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b10 || mem_addr_o !== 32'h0000_8000) begin
      miscompares++;
      $display("FAIL mid_grant: grant=%b addr=%h expected 10/00008000", grant_o, mem_addr_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_9000;
    tick(); mem_ack_i = 1'b0; dmmu_addr_i = 32'h0000_9000; #1;
    vectors++;
    if (mem_addr_o !== 32'h0000_9000 || mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pte: addr=%h req=%b expected 00009000/1", mem_addr_o, mem_req_o);
    end
    tick(); rst = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'h1234_5678; #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_first: got %h expected 0", all_out);
    end
    tick(); #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_held: got %h expected 0", all_out);
    end
    tick(); rst = 1'b0; mem_ack_i = 1'b0; #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_after: got %h expected 0", all_out);
    end
    tick(); #1;
    vectors++;
    if (grant_o !== 2'b01 || mem_addr_o !== 32'h0000_7000) begin
      miscompares++;
      $display("FAIL mid_regrant: grant=%b addr=%h expected 01/00007000", grant_o, mem_addr_o);
    end
    clear_inputs();
    tick(); tick();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    dmmu_ack_seen = 0;
    rst           = 1'b1;
    clear_inputs();
    test_reset();
    test_immu_only();
    test_tie_and_handover();
    test_err_wins();
    test_timeout();
    test_reset_mid_walk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
